// File: rtl/tqv_bus_pkg.sv
// Shared definitions for the TinyQV peripheral bus: size encodings, host FSM states
// and the read-data size masking helper.
package tqv_bus_pkg;

  localparam logic [1:0] SZ_B    = 2'b00;
  localparam logic [1:0] SZ_H    = 2'b01;
  localparam logic [1:0] SZ_W    = 2'b10;
  localparam logic [1:0] SZ_IDLE = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StWr,
    StRd,
    StRsp
  } host_state_e;

  // Zero-extend the low bytes of a bus word according to the transfer size.
  function automatic logic [31:0] size_mask(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] w_res;
    w_res = 32'h0;
    case (size)
      SZ_B:    w_res = {24'h0, data[7:0]};
      SZ_H:    w_res = {16'h0, data[15:0]};
      SZ_W:    w_res = data;
      default: w_res = 32'h0;
    endcase
    return w_res;
  endfunction

endpackage

// File: rtl/tqv_periph_host.sv
// Initiator for the TinyQV peripheral bus: converts a valid/ready command stream into
// single bus transactions and returns a registered response with timeout on reads.
module tqv_periph_host
  import tqv_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [1:0]  cmd_size,
  input  logic [5:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [5:0]  address,
  output logic [31:0] data_in,
  output logic [1:0]  data_write_n,
  output logic [1:0]  data_read_n,
  input  logic [31:0] data_out,
  input  logic        data_ready
);

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYC - 1);

  host_state_e r_state;
  logic        r_cmd_ready;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;
  logic [5:0]  r_address;
  logic [31:0] r_data_in;
  logic [1:0]  r_data_write_n;
  logic [1:0]  r_data_read_n;
  logic [7:0]  r_wait;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= StIdle;
      r_cmd_ready    <= 1'b1;
      r_rsp_valid    <= 1'b0;
      r_rsp_rdata    <= 32'h0;
      r_rsp_err      <= 1'b0;
      r_address      <= 6'h0;
      r_data_in      <= 32'h0;
      r_data_write_n <= SZ_IDLE;
      r_data_read_n  <= SZ_IDLE;
      r_wait         <= 8'h0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (cmd_valid) begin
            r_cmd_ready <= 1'b0;
            r_address   <= cmd_addr;
            r_data_in   <= cmd_wdata;
            if (cmd_size == SZ_IDLE) begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= 32'h0;
              r_state     <= StRsp;
            end else if (cmd_write) begin
              r_data_write_n <= cmd_size;
              r_state        <= StWr;
            end else begin
              r_data_read_n <= cmd_size;
              r_wait        <= 8'h0;
              r_state       <= StRd;
            end
          end
        end
        StWr: begin
          r_data_write_n <= SZ_IDLE;
          r_rsp_valid    <= 1'b1;
          r_rsp_err      <= 1'b0;
          r_rsp_rdata    <= 32'h0;
          r_state        <= StRsp;
        end
        StRd: begin
          // The held read strobe doubles as the transfer size for masking.
          if (data_ready) begin
            r_data_read_n <= SZ_IDLE;
            r_rsp_valid   <= 1'b1;
            r_rsp_err     <= 1'b0;
            r_rsp_rdata   <= size_mask(r_data_read_n, data_out);
            r_state       <= StRsp;
          end else if (r_wait == TimeoutLast) begin
            r_data_read_n <= SZ_IDLE;
            r_rsp_valid   <= 1'b1;
            r_rsp_err     <= 1'b1;
            r_rsp_rdata   <= 32'h0;
            r_state       <= StRsp;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        StRsp: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign cmd_ready    = r_cmd_ready;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_rdata    = r_rsp_rdata;
  assign rsp_err      = r_rsp_err;
  assign address      = r_address;
  assign data_in      = r_data_in;
  assign data_write_n = r_data_write_n;
  assign data_read_n  = r_data_read_n;

endmodule

// File: tb/tb_tqv_periph_host.sv
// Scoreboard bench for tqv_periph_host: expected bus cycles and responses are queued by the
// stimulus and checked by independent bus and response monitors.
module tb_tqv_periph_host;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [1:0]  cmd_size;
  logic [5:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;

  tqv_periph_host #(.TIMEOUT_CYC(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_size     (cmd_size),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .address      (address),
    .data_in      (data_in),
    .data_write_n (data_write_n),
    .data_read_n  (data_read_n),
    .data_out     (data_out),
    .data_ready   (data_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  typedef struct packed {
    logic        wr;
    logic [1:0]  sz;
    logic [7:0]  len;
    logic [5:0]  addr;
    logic [31:0] wdata;
  } bus_t;

  rsp_t rsp_q[$];
  bus_t bus_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   rd_delay = -1;
  bit   bus_skip = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Peripheral model: raise data_ready after rd_delay strobe cycles (negative = never).
  initial begin
    int cnt;
    cnt = 0;
    data_ready = 1'b0;
    data_out   = 32'h0;
    forever begin
      @(negedge clk);
      if (data_read_n != 2'b11) begin
        data_ready = (rd_delay >= 0) && (cnt == rd_delay);
        cnt++;
      end else begin
        data_ready = 1'b0;
        cnt = 0;
      end
    end
  end

  // Bus monitor: measures each strobe run and compares it with the queued expectation.
  initial begin
    int run;
    bus_t got;
    bus_t e;
    run = 0;
    got = '0;
    forever begin
      @(negedge clk);
      if (data_write_n != 2'b11 || data_read_n != 2'b11) begin
        check("strobe_exclusive", 32'(data_write_n != 2'b11 && data_read_n != 2'b11), 32'h0);
        if (run == 0) begin
          got.wr    = (data_write_n != 2'b11);
          got.sz    = got.wr ? data_write_n : data_read_n;
          got.addr  = address;
          got.wdata = data_in;
        end
        run++;
      end else if (run > 0) begin
        if (bus_skip) begin
          bus_skip = 1'b0;
        end else if (bus_q.size() == 0) begin
          check("unexpected_strobe", 32'(run), 32'h0);
        end else begin
          e = bus_q.pop_front();
          check("bus_is_write", 32'(got.wr), 32'(e.wr));
          check("bus_size", 32'(got.sz), 32'(e.sz));
          check("bus_strobe_len", 32'(run), 32'(e.len));
          check("bus_address", 32'(got.addr), 32'(e.addr));
          if (e.wr) check("bus_data_in", got.wdata, e.wdata);
        end
        run = 0;
      end
    end
  end

  // Response monitor: pops on every accepted response.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid && rsp_ready) begin
        if (rsp_q.size() == 0) begin
          check("unexpected_rsp", 32'h1, 32'h0);
        end else begin
          e = rsp_q.pop_front();
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_err", 32'(rsp_err), 32'(e.err));
        end
      end
    end
  end

  task automatic send_cmd(input logic wr, input logic [1:0] sz, input logic [5:0] addr,
                          input logic [31:0] wdata);
    int guard;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_size  = sz;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    guard = 0;
    while (!cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) begin
      check("cmd_accept_timeout", 32'h0, 32'h1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while ((rsp_q.size() != 0 || bus_q.size() != 0 || !cmd_ready) && guard < 100);
    if (rsp_q.size() != 0 || bus_q.size() != 0 || !cmd_ready)
      check("drain_timeout", 32'h0, 32'h1);
  endtask

  task automatic push(input logic wr, input logic [1:0] sz, input logic [7:0] len,
                      input logic [5:0] addr, input logic [31:0] wdata,
                      input logic [31:0] rdata, input logic err);
    if (len != 0) bus_q.push_back('{wr: wr, sz: sz, len: len, addr: addr, wdata: wdata});
    rsp_q.push_back('{rdata: rdata, err: err});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_size  = 2'b11;
    cmd_addr  = 6'h0;
    cmd_wdata = 32'h0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_cmd_ready", 32'(cmd_ready), 32'h1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset_rsp_rdata", rsp_rdata, 32'h0);
    check("reset_rsp_err", 32'(rsp_err), 32'h0);
    check("reset_address", 32'(address), 32'h0);
    check("reset_data_in", data_in, 32'h0);
    check("reset_write_n", 32'(data_write_n), 32'h3);
    check("reset_read_n", 32'(data_read_n), 32'h3);
    @(negedge clk);
    rst = 1'b0;

    // 32-bit write
    push(1'b1, 2'b10, 8'd1, 6'h00, 32'h6000_0000, 32'h0, 1'b0);
    send_cmd(1'b1, 2'b10, 6'h00, 32'h6000_0000);
    wait_idle();

    // 8-bit read, ready in the first cycle
    data_out = 32'hA5A5_A5A5;
    rd_delay = 0;
    push(1'b0, 2'b00, 8'd1, 6'h04, 32'h0, 32'h0000_00A5, 1'b0);
    send_cmd(1'b0, 2'b00, 6'h04, 32'h0);
    wait_idle();

    // 16-bit read, ready delayed 5 cycles
    data_out = 32'h1234_BEEF;
    rd_delay = 5;
    push(1'b0, 2'b01, 8'd6, 6'h08, 32'h0, 32'h0000_BEEF, 1'b0);
    send_cmd(1'b0, 2'b01, 6'h08, 32'h0);
    wait_idle();

    // Read timeout
    rd_delay = -1;
    push(1'b0, 2'b10, 8'd16, 6'h0C, 32'h0, 32'h0, 1'b1);
    send_cmd(1'b0, 2'b10, 6'h0C, 32'h0);
    wait_idle();

    // data_ready on the timeout cycle still succeeds
    data_out = 32'hDEAD_BEEF;
    rd_delay = 15;
    push(1'b0, 2'b10, 8'd16, 6'h1C, 32'h0, 32'hDEAD_BEEF, 1'b0);
    send_cmd(1'b0, 2'b10, 6'h1C, 32'h0);
    wait_idle();

    // Illegal size: no strobe, error on the cycle after accept
    push(1'b0, 2'b11, 8'd0, 6'h10, 32'h0, 32'h0, 1'b1);
    send_cmd(1'b0, 2'b11, 6'h10, 32'h0);
    check("illegal_rsp_valid", 32'(rsp_valid), 32'h1);
    check("illegal_rsp_err", 32'(rsp_err), 32'h1);
    wait_idle();

    // Backpressure: response held 10 cycles
    rsp_ready = 1'b0;
    data_out = 32'hCAFE_F00D;
    rd_delay = 0;
    push(1'b0, 2'b10, 8'd1, 6'h14, 32'h0, 32'hCAFE_F00D, 1'b0);
    send_cmd(1'b0, 2'b10, 6'h14, 32'h0);
    guard = 0;
    while (!rsp_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    for (int i = 0; i < 10; i++) begin
      check("bp_rsp_valid", 32'(rsp_valid), 32'h1);
      check("bp_rsp_rdata", rsp_rdata, 32'hCAFE_F00D);
      check("bp_cmd_ready", 32'(cmd_ready), 32'h0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_idle();

    // Reset during RD
    rd_delay = -1;
    bus_skip = 1'b1;
    send_cmd(1'b0, 2'b01, 6'h20, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_read_n", 32'(data_read_n), 32'h3);
    check("rst_write_n", 32'(data_write_n), 32'h3);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'h1);
    @(negedge clk);
    rst = 1'b0;

    // 8-bit write after reset
    push(1'b1, 2'b00, 8'd1, 6'h3F, 32'h0000_00FF, 32'h0, 1'b0);
    send_cmd(1'b1, 2'b00, 6'h3F, 32'h0000_00FF);
    wait_idle();
    check("final_address_hold", 32'(address), 32'h3F);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
